// File: rtl/instr_decode_stage_pkg.sv
// Shared widths and encodings for the ID stage: instruction opcodes and ALU commands.
package instr_decode_stage_pkg;

  localparam int WORD_LEN          = 16;
  localparam int REG_FILE_ADDR_LEN = 4;
  localparam int REG_FILE_SIZE     = 16;
  localparam int EXE_CMD_LEN       = 4;
  localparam int NUM_REGS          = 1 << REG_FILE_ADDR_LEN;
  localparam int IMM_LEN           = 8;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_CMP  = 4'b0101;
  localparam logic [3:0] OP_MOVI = 4'b0110;
  localparam logic [3:0] OP_MOVR = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_B    = 4'b1010;
  localparam logic [3:0] OP_LDR  = 4'b1100;
  localparam logic [3:0] OP_STR  = 4'b1101;

  localparam logic [EXE_CMD_LEN-1:0] CMD_NOP = 4'b0000;
  localparam logic [EXE_CMD_LEN-1:0] CMD_ADD = 4'b0001;
  localparam logic [EXE_CMD_LEN-1:0] CMD_SUB = 4'b0010;
  localparam logic [EXE_CMD_LEN-1:0] CMD_AND = 4'b0011;
  localparam logic [EXE_CMD_LEN-1:0] CMD_OR  = 4'b0100;
  localparam logic [EXE_CMD_LEN-1:0] CMD_MOV = 4'b0101;

endpackage

// File: rtl/instr_decode_stage_reg_file.sv
// 16x16 register file: async-clear, clocked write, two combinational write-through read ports.
module reg_file
  import instr_decode_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [REG_FILE_ADDR_LEN-1:0] waddr,
  input  logic [REG_FILE_SIZE-1:0]     wdata,
  input  logic [REG_FILE_ADDR_LEN-1:0] raddr1,
  input  logic [REG_FILE_ADDR_LEN-1:0] raddr2,
  output logic [REG_FILE_SIZE-1:0]     rdata1,
  output logic [REG_FILE_SIZE-1:0]     rdata2
);

  logic [REG_FILE_SIZE-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Reset dominates the bypass so reads are zero for the whole reset window.
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
    if (rst) begin
      rdata1 = '0;
      rdata2 = '0;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// ID stage: control decode, operand fetch, branch resolution and load-use / RAW stall detection.
module instr_decode_stage
  import instr_decode_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         forward_EN,
  input  logic                         writeEn,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest,
  input  logic [REG_FILE_SIZE-1:0]     writeVal,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest_EXE,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest_MEM,
  input  logic                         WB_EN_EXE,
  input  logic                         WB_EN_MEM,
  input  logic                         MEM_R_EN_EXE,
  input  logic                         flagZ,
  input  logic [WORD_LEN-1:0]          instruction,
  output logic                         is_imm,
  output logic                         ST,
  output logic                         hazard_detected,
  output logic                         brTaken,
  output logic                         MEM_R_EN,
  output logic                         MEM_W_EN,
  output logic                         WB_EN,
  output logic [EXE_CMD_LEN-1:0]       EXE_CMD,
  output logic [3:0]                   branch_comm,
  output logic [REG_FILE_ADDR_LEN-1:0] src1,
  output logic [REG_FILE_ADDR_LEN-1:0] src2,
  output logic [REG_FILE_SIZE-1:0]     val1,
  output logic [REG_FILE_SIZE-1:0]     val2
);

  logic [3:0]                   op;
  logic [REG_FILE_ADDR_LEN-1:0] rd, rs1, rs2;
  logic [IMM_LEN-1:0]           imm8;
  logic [REG_FILE_SIZE-1:0]     rf_rd2;

  assign op   = instruction[15:12];
  assign rd   = instruction[11:8];
  assign rs1  = instruction[7:4];
  assign rs2  = instruction[3:0];
  assign imm8 = instruction[7:0];

  logic [EXE_CMD_LEN-1:0] dec_cmd;
  logic dec_wb, dec_mr, dec_mw, dec_st, dec_imm, dec_taken, dec_br;
  logic use1, use2;

  always_comb begin
    dec_cmd   = CMD_NOP;
    dec_wb    = 1'b0;
    dec_mr    = 1'b0;
    dec_mw    = 1'b0;
    dec_st    = 1'b0;
    dec_imm   = 1'b0;
    dec_taken = 1'b0;
    dec_br    = 1'b0;
    use1      = 1'b0;
    use2      = 1'b0;
    case (op)
      OP_ADD:  begin dec_cmd = CMD_ADD; dec_wb = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      OP_SUB:  begin dec_cmd = CMD_SUB; dec_wb = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      OP_AND:  begin dec_cmd = CMD_AND; dec_wb = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      OP_OR:   begin dec_cmd = CMD_OR;  dec_wb = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      OP_CMP:  begin dec_cmd = CMD_SUB; use1 = 1'b1; use2 = 1'b1; end
      OP_MOVI: begin dec_cmd = CMD_MOV; dec_wb = 1'b1; dec_imm = 1'b1; end
      OP_MOVR: begin dec_cmd = CMD_MOV; dec_wb = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      OP_BEQ:  begin dec_imm = 1'b1; dec_br = 1'b1; dec_taken = flagZ; end
      OP_BNE:  begin dec_imm = 1'b1; dec_br = 1'b1; dec_taken = ~flagZ; end
      OP_B:    begin dec_imm = 1'b1; dec_br = 1'b1; dec_taken = 1'b1; end
      OP_LDR:  begin dec_cmd = CMD_MOV; dec_mr = 1'b1; dec_wb = 1'b1; use1 = 1'b1; end
      OP_STR:  begin dec_cmd = CMD_MOV; dec_mw = 1'b1; dec_st = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      default: ;
    endcase
  end

  // Stores read their data register through the second port.
  assign src1 = rs1;
  assign src2 = dec_st ? rd : rs2;

  reg_file u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (writeEn),
    .waddr  (dest),
    .wdata  (writeVal),
    .raddr1 (src1),
    .raddr2 (src2),
    .rdata1 (val1),
    .rdata2 (rf_rd2)
  );

  assign val2 = dec_imm ? {{(REG_FILE_SIZE-IMM_LEN){imm8[IMM_LEN-1]}}, imm8} : rf_rd2;

  logic hit_exe, hit_mem;
  assign hit_exe = WB_EN_EXE && ((use1 && src1 == dest_EXE) || (use2 && src2 == dest_EXE));
  assign hit_mem = WB_EN_MEM && ((use1 && src1 == dest_MEM) || (use2 && src2 == dest_MEM));

  // With forwarding only a load still in EXE cannot be bypassed in time.
  assign hazard_detected = forward_EN ? (MEM_R_EN_EXE && hit_exe) : (hit_exe || hit_mem);

  assign is_imm      = dec_imm;
  assign ST          = dec_st;
  assign branch_comm = dec_br ? op : 4'b0000;
  assign WB_EN       = dec_wb    & ~hazard_detected;
  assign MEM_R_EN    = dec_mr    & ~hazard_detected;
  assign MEM_W_EN    = dec_mw    & ~hazard_detected;
  assign brTaken     = dec_taken & ~hazard_detected;
  assign EXE_CMD     = hazard_detected ? CMD_NOP : dec_cmd;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: hand-computed decode, operand, branch and hazard vectors.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        forward_EN, writeEn;
  logic [3:0]  dest, dest_EXE, dest_MEM;
  logic [15:0] writeVal, instruction;
  logic        WB_EN_EXE, WB_EN_MEM, MEM_R_EN_EXE, flagZ;
  logic        is_imm, ST, hazard_detected, brTaken, MEM_R_EN, MEM_W_EN, WB_EN;
  logic [3:0]  EXE_CMD, branch_comm, src1, src2;
  logic [15:0] val1, val2;

  int checks = 0;
  int errors = 0;

  instr_decode_stage dut (
    .clk(clk), .rst(rst), .forward_EN(forward_EN), .writeEn(writeEn), .dest(dest),
    .writeVal(writeVal), .dest_EXE(dest_EXE), .dest_MEM(dest_MEM), .WB_EN_EXE(WB_EN_EXE),
    .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_EXE(MEM_R_EN_EXE), .flagZ(flagZ),
    .instruction(instruction), .is_imm(is_imm), .ST(ST), .hazard_detected(hazard_detected),
    .brTaken(brTaken), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN),
    .EXE_CMD(EXE_CMD), .branch_comm(branch_comm), .src1(src1), .src2(src2),
    .val1(val1), .val2(val2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rf_write(input logic [3:0] a, input logic [15:0] v);
    @(negedge clk);
    writeEn = 1'b1; dest = a; writeVal = v;
    @(posedge clk); #1;
    writeEn = 1'b0;
  endtask

  initial begin
    rst = 1'b1; forward_EN = 1'b0; writeEn = 1'b0; dest = '0; writeVal = '0;
    dest_EXE = '0; dest_MEM = '0; WB_EN_EXE = 1'b0; WB_EN_MEM = 1'b0;
    MEM_R_EN_EXE = 1'b0; flagZ = 1'b0; instruction = 16'h0093;
    #1;
    check("rst_val1", val1, 16'h0000);
    check("rst_val2", val2, 16'h0000);
    @(posedge clk); #2 rst = 1'b0; #1;
    check("post_rst_val1", val1, 16'h0000);

    rf_write(4'd9, 16'h0012);
    rf_write(4'd3, 16'h0005);

    // ADD r0, r9, r3
    instruction = 16'h0093; #1;
    check("add_src1", src1, 16'd9);
    check("add_src2", src2, 16'd3);
    check("add_val1", val1, 16'h0012);
    check("add_val2", val2, 16'h0005);
    check("add_wb", WB_EN, 1'b1);
    check("add_cmd", EXE_CMD, 4'b0001);
    check("add_haz", hazard_detected, 1'b0);
    check("add_imm", is_imm, 1'b0);

    instruction = 16'h5093; #1;
    check("cmp_cmd", EXE_CMD, 4'b0010);
    check("cmp_wb", WB_EN, 1'b0);

    instruction = 16'h6093; #1;
    check("movi_imm", is_imm, 1'b1);
    check("movi_val2", val2, 16'hFF93);
    check("movi_cmd", EXE_CMD, 4'b0101);
    check("movi_wb", WB_EN, 1'b1);

    instruction = 16'h7093; #1;
    check("movr_cmd", EXE_CMD, 4'b0101);
    check("movr_val2", val2, 16'h0005);

    instruction = 16'h8005; flagZ = 1'b0; #1;
    check("beq_nz_taken", brTaken, 1'b0);
    check("beq_comm", branch_comm, 4'b1000);
    check("beq_cmd", EXE_CMD, 4'b0000);
    flagZ = 1'b1; #1;
    check("beq_z_taken", brTaken, 1'b1);
    check("beq_val2", val2, 16'h0005);

    instruction = 16'h9005; #1;
    check("bne_z_taken", brTaken, 1'b0);
    check("bne_comm", branch_comm, 4'b1001);
    instruction = 16'hA0FF; #1;
    check("b_taken", brTaken, 1'b1);
    check("b_val2", val2, 16'hFFFF);
    flagZ = 1'b0;

    instruction = 16'hC093; #1;
    check("ldr_mr", MEM_R_EN, 1'b1);
    check("ldr_wb", WB_EN, 1'b1);
    check("ldr_mw", MEM_W_EN, 1'b0);
    check("ldr_cmd", EXE_CMD, 4'b0101);

    instruction = 16'hD293; #1;
    check("str_st", ST, 1'b1);
    check("str_mw", MEM_W_EN, 1'b1);
    check("str_src2", src2, 16'd2);
    check("str_wb", WB_EN, 1'b0);
    check("str_val2", val2, 16'h0000);

    instruction = 16'hF093; #1;
    check("nop_cmd", EXE_CMD, 4'b0000);
    check("nop_wb", WB_EN, 1'b0);
    check("nop_comm", branch_comm, 4'b0000);

    // Load-use with forwarding
    forward_EN = 1'b1; MEM_R_EN_EXE = 1'b1; WB_EN_EXE = 1'b1; dest_EXE = 4'd9;
    instruction = 16'h0093; #1;
    check("lu_haz", hazard_detected, 1'b1);
    check("lu_wb", WB_EN, 1'b0);
    check("lu_cmd", EXE_CMD, 4'b0000);
    instruction = 16'h6093; #1;
    check("lu_movi_haz", hazard_detected, 1'b0);
    instruction = 16'h0093; MEM_R_EN_EXE = 1'b0; #1;
    check("fwd_nohaz", hazard_detected, 1'b0);
    check("fwd_wb", WB_EN, 1'b1);
    WB_EN_EXE = 1'b0; WB_EN_MEM = 1'b1; dest_MEM = 4'd3; #1;
    check("fwd_mem_nohaz", hazard_detected, 1'b0);
    forward_EN = 1'b0; #1;
    check("nofwd_mem_haz", hazard_detected, 1'b1);
    WB_EN_MEM = 1'b0; WB_EN_EXE = 1'b1; dest_EXE = 4'd9; #1;
    check("nofwd_exe_haz", hazard_detected, 1'b1);
    dest_EXE = 4'd5; #1;
    check("nofwd_exe_miss", hazard_detected, 1'b0);
    WB_EN_EXE = 1'b0; dest_EXE = '0; dest_MEM = '0;

    // Write-through in the same cycle, then registered value
    @(negedge clk);
    writeEn = 1'b1; dest = 4'd9; writeVal = 16'hABCD; #1;
    check("wt_val1", val1, 16'hABCD);
    @(posedge clk); #1 writeEn = 1'b0; #1;
    check("wr_val1", val1, 16'hABCD);

    #2 rst = 1'b1; #1;
    check("rst_async_val1", val1, 16'h0000);
    #2 rst = 1'b0; #1;
    check("rst_clr_val1", val1, 16'h0000);
    check("rst_clr_val2", val2, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
Instruction-decode (ID) stage of the 16-bit pipelined core. It contains a 16x16 register file and a control decoder, plus branch-condition and hazard logic. It takes the fetched instruction and produces EXE control signals, source addresses/values and a stall request. Write-back data enters from the WB stage; EXE/MEM destination info enters for hazard detection.

Parameters:
WORD_LEN, 16, instruction width
REG_FILE_ADDR_LEN, 4, register address width (16 registers)
REG_FILE_SIZE, 16, register data width
EXE_CMD_LEN, 4, ALU command width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
forward_EN  in  1  1 = forwarding unit present (stall only on load-use)
writeEn  in  1  WB write enable
dest  in  4  WB destination register
writeVal  in  16  WB data
dest_EXE, dest_MEM  in  4  destinations in EXE / MEM
WB_EN_EXE, WB_EN_MEM  in  1  write-back pending in EXE / MEM
MEM_R_EN_EXE  in  1  instruction in EXE is a load
flagZ  in  1  zero flag from status register
instruction  in  16  fetched instruction
is_imm  out  1  val2 is the immediate
ST  out  1  instruction is a store
hazard_detected  out  1  stall IF/ID
brTaken  out  1  branch taken
MEM_R_EN, MEM_W_EN, WB_EN  out  1  control to later stages
EXE_CMD  out  4  ALU command
branch_comm  out  4  branch code (opcode of branch, else 0)
src1, src2  out  4  source register addresses
val1, val2  out  16  operand values

Behaviour:
- Format: op=[15:12], rd=[11:8], rs1=[7:4], rs2=[3:0], imm8=[7:0].
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR: EXE_CMD 0001/0010/0011/0100, WB_EN=1.
  - 0101 CMP: EXE_CMD SUB, WB_EN=0.
  - 0110 MOVI: EXE_CMD 0101 (MOV), is_imm=1, WB_EN=1.
  - 0111 MOVR: MOV rs2, WB_EN=1.
  - 1000 BEQ, 1001 BNE, 1010 B: is_imm=1, EXE_CMD 0000.
  - 1100 LDR rd,[rs1]: EXE_CMD MOV, MEM_R_EN=1, WB_EN=1.
  - 1101 STR rd,[rs1]: EXE_CMD MOV, MEM_W_EN=1, ST=1.
  - All other opcodes are NOP: all controls 0.
- src1=rs1; src2 = rd when ST, else rs2.
- val1 = RF[src1].
- val2 = sign-extended imm8 when is_imm, else RF[src2].
- Register file:
  - 16 registers, written on the rising clk edge when writeEn.
  - Read is combinational with write-through: if writeEn and dest equals the read address, return writeVal.
  - rst clears all registers to 0 asynchronously.
- Branch logic: brTaken = (BEQ & flagZ) | (BNE & ~flagZ) | B. branch_comm = op for 1000/1001/1010, else 0000.
- Hazard logic:
  - An operand is used if: src1 for all ops except MOVI and branches; src2 for two-register ALU ops, CMP, MOVR and STR.
  - If forward_EN=0: hazard when a used src equals dest_EXE with WB_EN_EXE, or equals dest_MEM with WB_EN_MEM.
  - If forward_EN=1: hazard only when MEM_R_EN_EXE & WB_EN_EXE & a used src == dest_EXE.
- On a hazard, WB_EN, MEM_R_EN, MEM_W_EN and brTaken are forced to 0; EXE_CMD is forced to 0000.
- All outputs are combinational, with zero-cycle latency. Under reset, RF reads return 0.

Decomposition:
- Shared package: width constants, opcode and EXE_CMD encodings.
- Sub-module reg_file: 16x16, async reset, write-through read ports.
- Decoder, branch and hazard logic stay inline.

Test Plan:
- Reset, write R9=0x0012 and R3=0x0005 via writeEn, then ADD 0x0093 -> src1=9, src2=3, val1=0x0012, val2=0x0005, WB_EN=1, EXE_CMD=0001, hazard=0.
- CMP 0x5093 -> EXE_CMD=0010, WB_EN=0. MOVI 0x6093 -> is_imm=1, val2=0xFF93, EXE_CMD=0101.
- BEQ 0x8005 with flagZ=0 -> brTaken=0, branch_comm=1000. Same with flagZ=1 -> brTaken=1, val2=0x0005.
- LDR 0xC093 -> MEM_R_EN=1, WB_EN=1. STR 0xD293 -> ST=1, MEM_W_EN=1, src2=2, WB_EN=0.
- forward_EN=1, MEM_R_EN_EXE=1, WB_EN_EXE=1, dest_EXE=9, ADD 0x0093 -> hazard=1, WB_EN=0. Same with MEM_R_EN_EXE=0 -> hazard=0. With forward_EN=0, WB_EN_MEM=1, dest_MEM=3 -> hazard=1.
- writeEn=1, dest=9, writeVal=0xABCD during ADD 0x0093 -> val1=0xABCD in the same cycle. Assert rst mid-run -> val1=0 immediately.
